// File: rtl/recur_ctrl.sv
// Iterative F(n) evaluator: an explicit LIFO stack replaces recursion and drives the base-case ALU.
// Optional macro RECUR_PEAK_EN adds a peak_depth output (maximum stack pointer seen per evaluation).
module recur_ctrl #(
  parameter  int SIZE  = 4,
  parameter  int DEPTH = 16,
  parameter  int ACC_W = 16,
  localparam int SPW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIZE-1:0]  n_in,
  output logic             busy,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow,
  output logic             alu,
  output logic             twothree,
  output logic [SIZE-1:0]  n,
  output logic [SIZE-1:0]  m2,
  output logic [SIZE-1:0]  m3,
  input  logic [SIZE-1:0]  alu_result,
  input  logic             alu_done,
  input  logic             alu_backtrack
`ifdef RECUR_PEAK_EN
  ,
  output logic [SPW-1:0]   peak_depth
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE, POP, S_N, E_N, S_2, E_2, S_3, E_3, FIN
  } state_t;

  state_t            state, next;
  logic [SIZE-1:0]   x;
  logic [SPW-1:0]    sp;
  logic [ACC_W-1:0]  acc;
  logic [SIZE-1:0]   stack [DEPTH];

  logic              accept, push, pop, add, ovf_set, full;
  logic [SIZE-1:0]   push_val;
  logic [AW-1:0]     rd_idx, wr_idx;

  assign accept = (state == IDLE) && start;
  assign full   = (sp == SPW'(DEPTH));
  assign rd_idx = AW'(sp - SPW'(1));
  assign wr_idx = AW'(sp);

  assign n  = x;
  assign m2 = (x >= SIZE'(2)) ? x - SIZE'(2) : '0;
  assign m3 = (x >= SIZE'(3)) ? x - SIZE'(3) : '0;

  assign busy      = (state != IDLE) && (state != FIN);
  assign out_valid = (state == FIN);

  // Operands stay stable across each SETUP/EVAL pair; alu rises only in EVAL states.
  always_comb begin
    next     = state;
    push     = 1'b0;
    push_val = m2;
    pop      = 1'b0;
    add      = 1'b0;
    ovf_set  = 1'b0;
    alu      = 1'b0;
    twothree = 1'b0;
    case (state)
      IDLE: if (start) next = POP;
      POP: begin
        if (sp == '0) next = FIN;
        else begin
          pop  = 1'b1;
          next = S_N;
        end
      end
      S_N: next = E_N;
      E_N: begin
        alu = 1'b1;
        if (alu_done) begin
          add  = 1'b1;
          next = POP;
        end else next = S_2;
      end
      S_2: begin
        twothree = 1'b1;
        next     = E_2;
      end
      E_2: begin
        alu      = 1'b1;
        twothree = 1'b1;
        next     = S_3;
        if (alu_backtrack) add = 1'b1;
        else if (full) begin
          ovf_set = 1'b1;
          next    = FIN;
        end else push = 1'b1;
      end
      S_3: next = E_3;
      E_3: begin
        alu      = 1'b1;
        push_val = m3;
        next     = POP;
        if (alu_backtrack) add = 1'b1;
        else if (full) begin
          ovf_set = 1'b1;
          next    = FIN;
        end else push = 1'b1;
      end
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sp       <= '0;
      acc      <= '0;
      x        <= '0;
      out_sum  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        sp       <= SPW'(1);
        acc      <= '0;
        out_sum  <= '0;
        overflow <= 1'b0;
      end
      if (pop) begin
        x  <= stack[rd_idx];
        sp <= sp - SPW'(1);
      end
      if (push)    sp       <= sp + SPW'(1);
      if (add)     acc      <= acc + ACC_W'(alu_result);
      if (ovf_set) overflow <= 1'b1;
      // acc is never updated in a cycle that enters FIN, so it is final here.
      if (next == FIN) out_sum <= acc;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)    stack[0]      <= n_in;
    else if (push) stack[wr_idx] <= push_val;
  end

`ifdef RECUR_PEAK_EN
  always_ff @(posedge clk) begin
    if (rst)         peak_depth <= '0;
    else if (accept) peak_depth <= SPW'(1);
    else if (push && (sp + SPW'(1) > peak_depth)) peak_depth <= sp + SPW'(1);
  end
`endif

endmodule

// File: tb/tb_recur_ctrl.sv
// Directed bench for recur_ctrl: a DEPTH=16 and a DEPTH=2 instance, each driven by a behavioural base-case ALU.
module tb_recur_ctrl;

  logic clk = 1'b0;
  logic rst, start_m, start_s;
  logic [3:0] nin_m, nin_s;
  always #5 clk = ~clk;

  logic        busy_m, ov_m, ovf_m, alu_m, tt_m, done_m, bt_m;
  logic [15:0] sum_m;
  logic [3:0]  n_m, m2_m, m3_m, res_m;
  logic        busy_s, ov_s, ovf_s, alu_s, tt_s, done_s, bt_s;
  logic [15:0] sum_s;
  logic [3:0]  n_s, m2_s, m3_s, res_s;
`ifdef RECUR_PEAK_EN
  logic [4:0]  peak_m;
  logic [1:0]  peak_s;
`endif

  recur_ctrl #(.SIZE(4), .DEPTH(16), .ACC_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start_m), .n_in(nin_m),
    .busy(busy_m), .out_valid(ov_m), .out_sum(sum_m), .overflow(ovf_m),
    .alu(alu_m), .twothree(tt_m), .n(n_m), .m2(m2_m), .m3(m3_m),
    .alu_result(res_m), .alu_done(done_m), .alu_backtrack(bt_m)
`ifdef RECUR_PEAK_EN
    , .peak_depth(peak_m)
`endif
  );

  recur_ctrl #(.SIZE(4), .DEPTH(2), .ACC_W(16)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .n_in(nin_s),
    .busy(busy_s), .out_valid(ov_s), .out_sum(sum_s), .overflow(ovf_s),
    .alu(alu_s), .twothree(tt_s), .n(n_s), .m2(m2_s), .m3(m3_s),
    .alu_result(res_s), .alu_done(done_s), .alu_backtrack(bt_s)
`ifdef RECUR_PEAK_EN
    , .peak_depth(peak_s)
`endif
  );

  // ALU model: outputs update only on a rising alu, so sampling before EVAL sees stale data.
  int n2_pulses = 0, done_pulses = 0;
  initial begin
    done_m = 0; bt_m = 0; res_m = 0;
    done_s = 0; bt_s = 0; res_s = 0;
  end
  always @(posedge alu_m) begin
    done_m = (n_m <= 4'd1);
    bt_m   = tt_m ? (m2_m <= 4'd1) : (m3_m <= 4'd1);
    res_m  = (done_m || bt_m) ? 4'd1 : 4'd0;
    if (n_m == 4'd2) n2_pulses++;
    if (done_m) done_pulses++;
  end
  always @(posedge alu_s) begin
    done_s = (n_s <= 4'd1);
    bt_s   = tt_s ? (m2_s <= 4'd1) : (m3_s <= 4'd1);
    res_s  = (done_s || bt_s) ? 4'd1 : 4'd0;
  end

  int alu_viol = 0;
  logic alu_prev_m = 1'b0, alu_prev_s = 1'b0;
  always @(negedge clk) begin
    if ((alu_m && alu_prev_m) || (alu_s && alu_prev_s)) alu_viol++;
    alu_prev_m = alu_m;
    alu_prev_s = alu_s;
  end

  int total = 0, npass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic kick(input bit sel, input logic [3:0] v);
    if (sel) begin start_s = 1'b1; nin_s = v; end
    else     begin start_m = 1'b1; nin_m = v; end
    tick();
    start_m = 1'b0; start_s = 1'b0;
  endtask

  // Cycle counter starts at 1: kick has already consumed the start cycle.
  task automatic wait_done(input bit sel, input string tag, output int cyc);
    cyc = 1;
    while (!(sel ? ov_s : ov_m) && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk({tag, "_done"}, (sel ? ov_s : ov_m), 1'b1);
  endtask

  int cyc, seen;

  initial begin
    rst = 1'b1; start_m = 0; start_s = 0; nin_m = 0; nin_s = 0;
    tick(); tick();
    chk("rst_valid", ov_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_sum", sum_m, 0);
    chk("rst_ovf", ovf_m, 0);
    chk("rst_alu", alu_m, 0);
    chk("rst_n", n_m, 0);
    rst = 1'b0;
    tick();

    // n=0: single leaf
    done_pulses = 0;
    kick(0, 4'd0);
    chk("n0_busy", busy_m, 1);
    wait_done(0, "n0", cyc);
    chk("n0_latency", cyc, 5);
    chk("n0_sum", sum_m, 1);
    chk("n0_ovf", ovf_m, 0);
    chk("n0_done_pulses", done_pulses, 1);
    tick();
    chk("n0_valid_pulse", ov_m, 0);
    chk("n0_busy_after", busy_m, 0);

    // n=4: node 2 visited once (three ALU evaluations)
    n2_pulses = 0;
    kick(0, 4'd4);
    wait_done(0, "n4", cyc);
    chk("n4_sum", sum_m, 3);
    chk("n4_node2_evals", n2_pulses, 3);
    tick();

    kick(0, 4'd7);
    wait_done(0, "n7", cyc);
    chk("n7_sum", sum_m, 7);
`ifdef RECUR_PEAK_EN
    chk("n7_peak", peak_m, 2);
`endif
    tick();

    kick(0, 4'd15);
    wait_done(0, "n15", cyc);
    chk("n15_sum", sum_m, 65);
    chk("n15_ovf", ovf_m, 0);
    tick();

    // DEPTH=2: overflow aborts before any leaf is accumulated
    kick(1, 4'd15);
    wait_done(1, "small15", cyc);
    chk("small15_ovf", ovf_s, 1);
    chk("small15_partial", sum_s, 0);
    tick();
    chk("small15_ovf_sticky", ovf_s, 1);
    kick(1, 4'd4);
    chk("small4_ovf_clr", ovf_s, 0);
    wait_done(1, "small4", cyc);
    chk("small4_sum", sum_s, 3);
    tick();

    // start while busy is ignored
    kick(0, 4'd6);
    start_m = 1'b1; nin_m = 4'd9; tick();
    nin_m = 4'd3; tick();
    nin_m = 4'd15; tick();
    start_m = 1'b0;
    wait_done(0, "ign", cyc);
    chk("ignore_sum", sum_m, 5);
    tick();

    // reset mid-evaluation
    kick(0, 4'd9);
    repeat (20) tick();
    chk("mid_busy_pre", busy_m, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_valid", ov_m, 0);
    chk("mid_busy", busy_m, 0);
    chk("mid_sum", sum_m, 0);
    chk("mid_alu", alu_m, 0);
    chk("mid_n", n_m, 0);
    seen = 0;
    repeat (30) begin
      tick();
      if (ov_m) seen++;
    end
    chk("mid_no_valid", seen, 0);
    kick(0, 4'd5);
    wait_done(0, "n5", cyc);
    chk("n5_sum", sum_m, 4);
    tick();

    chk("alu_consecutive", alu_viol, 0);
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
